// File: rtl/uart_rx_param.sv
// Oversampled UART receiver with majority-vote bit decisions, optional parity,
// 1 or 2 stop bits, break lockout and a valid/ready output holding register.
module uart_rx_param #(
   parameter int DATA_BITS   = 7,
   parameter int OVERSAMPLE  = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 rx,
   input  logic                 ready_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 valid_out,
   output logic                 parity_err_out,
   output logic                 frame_err_out,
   output logic                 overrun_out,
   output logic [2:0]           state_out
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2);
   localparam logic          ODD_PAR   = (PARITY_MODE == 2);
   localparam logic          HAS_PAR   = (PARITY_MODE != 0);

   logic                 r_sync1, r_sync2;
   logic [1:0]           r_hist;
   logic [2:0]           r_state;
   logic [CW-1:0]        r_cnt;
   logic [BW-1:0]        r_bitcnt;
   logic                 r_stopcnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_err;
   logic                 r_frm_acc;
   logic                 r_armed;

   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid, r_perr, r_ferr, r_ovr;

   logic w_maj, w_bit_end, w_deliver, w_frame_err, w_accept;

   // Majority over the two previous tick samples plus the current one.
   assign w_maj       = (r_hist[1] & r_hist[0]) | (r_hist[1] & r_sync2) | (r_hist[0] & r_sync2);
   assign w_bit_end   = ena && (r_cnt == CNT_LAST);
   assign w_deliver   = w_bit_end && (r_state == S_STOP) && (r_stopcnt == STOP_LAST);
   assign w_frame_err = r_frm_acc | ~w_maj;
   assign w_accept    = r_valid & ready_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_hist    <= 2'b11;
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_bitcnt  <= '0;
         r_stopcnt <= 1'b0;
         r_shift   <= '0;
         r_par_err <= 1'b0;
         r_frm_acc <= 1'b0;
         r_armed   <= 1'b1;
      end else begin
         r_sync1 <= rx;
         r_sync2 <= r_sync1;
         if (ena) begin
            r_hist <= {r_hist[0], r_sync2};
            case (r_state)
               S_IDLE: begin
                  r_cnt <= '0;
                  // After a frame error, wait for the line to go high before listening again.
                  if (!r_armed) begin
                     if (r_sync2) r_armed <= 1'b1;
                  end else if (!r_sync2) begin
                     r_state <= S_START;
                  end
               end
               S_START: begin
                  if (r_cnt == CNT_HALF) begin
                     r_cnt    <= '0;
                     r_bitcnt <= '0;
                     r_state  <= w_maj ? S_IDLE : S_DATA;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               S_DATA: begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt    <= '0;
                     r_shift  <= {w_maj, r_shift[DATA_BITS-1:1]};
                     r_bitcnt <= r_bitcnt + BW'(1);
                     if (r_bitcnt == BIT_LAST) begin
                        r_bitcnt  <= '0;
                        r_stopcnt <= 1'b0;
                        r_frm_acc <= 1'b0;
                        r_par_err <= 1'b0;
                        r_state   <= HAS_PAR ? S_PARITY : S_STOP;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               S_PARITY: begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt     <= '0;
                     r_par_err <= (^r_shift) ^ w_maj ^ ODD_PAR;
                     r_state   <= S_STOP;
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               S_STOP: begin
                  if (r_cnt == CNT_LAST) begin
                     r_cnt     <= '0;
                     r_stopcnt <= r_stopcnt + 1'b1;
                     if (!w_maj) r_frm_acc <= 1'b1;
                     if (r_stopcnt == STOP_LAST) begin
                        r_state <= S_IDLE;
                        if (w_frame_err) r_armed <= 1'b0;
                     end
                  end else begin
                     r_cnt <= r_cnt + CW'(1);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Output holding register; runs every cycle independent of ena.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
      end else if (w_deliver) begin
         if (r_valid && !ready_in) begin
            r_ovr <= 1'b1;
         end else begin
            r_data  <= r_shift;
            r_perr  <= r_par_err;
            r_ferr  <= w_frame_err;
            r_valid <= 1'b1;
            if (w_accept) r_ovr <= 1'b0;
         end
      end else if (w_accept) begin
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end
   end

   assign data_out       = r_data;
   assign valid_out      = r_valid;
   assign parity_err_out = r_perr;
   assign frame_err_out  = r_ferr;
   assign overrun_out    = r_ovr;
   assign state_out      = r_state;

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 7, number of data bits per frame, legal range 5-9.
REQ-002 SHALL provide parameter OVERSAMPLE, default 8, oversample ticks per bit, even, legal range 4-16.
REQ-003 SHALL provide parameter PARITY_MODE, default 0, where 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL provide parameter STOP_BITS, default 1, legal values 1 or 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ena, input, 1 bit: oversample tick; each cycle with ena=1 is one tick.
REQ-008 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-009 SHALL have port ready_in, input, 1 bit: consumer accepts the word when valid_out=1.
REQ-010 SHALL have port data_out, output, DATA_BITS bits: received word.
REQ-011 SHALL have port valid_out, output, 1 bit: data_out and the error flags are valid.
REQ-012 SHALL have port parity_err_out, output, 1 bit: parity mismatch on the held word.
REQ-013 SHALL have port frame_err_out, output, 1 bit: a stop bit of the held word was sampled low.
REQ-014 SHALL have port overrun_out, output, 1 bit: sticky flag, a frame was dropped.
REQ-015 SHALL have port state_out, output, 3 bits: current state, IDLE=0, START=1, DATA=2, PARITY=3, STOP=4.

Function
REQ-016 SHALL pass rx through a 2-flop synchronizer (always clocked, not gated by ena); the bit decision SHALL be the majority of the last 3 synchronized values seen on ticks.
REQ-017 SHALL freeze all state, counters and synchronized-sample history on cycles with ena=0; the output handshake SHALL operate every cycle regardless of ena.
REQ-018 IDLE: when armed and the synchronized rx=0 on a tick, SHALL go to START with tick counter=0.
REQ-019 START: at tick OVERSAMPLE/2-1, majority=0 SHALL go to DATA with counter=0; majority=1 is a false start and SHALL return to IDLE.
REQ-020 DATA: SHALL sample on each tick where counter=OVERSAMPLE-1, shifting in LSB first.
REQ-021 After DATA_BITS samples, SHALL go to PARITY if PARITY_MODE!=0, otherwise to STOP.
REQ-022 PARITY: SHALL take one sample and compute error = XOR(data bits, parity bit) XOR (PARITY_MODE==2).
REQ-023 STOP: SHALL take STOP_BITS samples; any sample=0 sets the frame error for the word.
REQ-024 SHALL return to IDLE on the tick of the last stop sample.
REQ-025 Word delivery SHALL occur on the cycle after the last stop sample: data_out and both error flags load, and valid_out=1.
REQ-026 A word with frame or parity error SHALL still be delivered, with its error flags set.
REQ-027 valid_out SHALL stay 1 until a cycle with ready_in=1; it SHALL clear on the next edge, with data_out holding its value.
REQ-028 If delivery occurs while valid_out=1 and ready_in=0, the new word SHALL be dropped, the held word kept, and overrun_out set.
REQ-029 overrun_out SHALL clear only on an accept (valid_out & ready_in).
REQ-030 If delivery coincides with an accept, the new word SHALL load, valid_out SHALL remain 1, and overrun_out SHALL NOT be set.
REQ-031 The receiver SHALL be armed after reset; a frame error SHALL disarm it.
REQ-032 When disarmed, the receiver SHALL re-arm only after one tick with synchronized rx=1, so a held-low line (break) yields exactly one frame-error word.
REQ-033 The counter SHALL be ceil(log2(OVERSAMPLE)) bits wide and wrap to 0 after each sample; the bit counter SHALL be sized for DATA_BITS.

Reset
REQ-034 rst=1 at a clock edge SHALL set state IDLE, counters 0, shift register 0, data_out 0, valid_out 0, parity_err_out 0, frame_err_out 0, overrun_out 0, synchronizer and sample history all 1, and armed 1.
REQ-035 rst SHALL override ena and any in-progress frame; a partial frame SHALL be discarded with no valid_out.

Verification (DATA_BITS=7, OVERSAMPLE=8, ena=1 every cycle unless stated)
REQ-036 PARITY_MODE=0, frame 0x55, ready_in=1 -> data_out=7'h55, valid_out pulses for 1 cycle, all error flags 0, state sequence 1,2,4,0.
REQ-037 PARITY_MODE=1, data 0x03 with parity bit 1 -> data_out=7'h03, parity_err_out=1, valid_out=1; the same data with parity bit 0 -> parity_err_out=0.
REQ-038 rx low for 3 ticks then high -> state returns to 0 from START, valid_out never asserts.
REQ-039 Two frames 0x12 then 0x34 with ready_in=0 -> data_out=7'h12, overrun_out=1; then ready_in=1 for one cycle -> valid_out=0, overrun_out=0.
REQ-040 Stop bit low on data 0x7F, then rx held low for 30 ticks, then high -> exactly one word with frame_err_out=1, no further START until rx has been high.
REQ-041 rst=1 mid-DATA, then a clean 0x2A frame -> all outputs at reset values after the reset edge, then data_out=7'h2A with no error flags.
